hash_feeder: RTL and testbench

Upstream stage of the SHA3 padder in the ROLLO-II decrypt hash path. On `start`, it walks the packed-vector RAM (digit field elements of m bits per word, ceil(n/digit) words), fetches one word at a time and presents it to the padder as `in`/`in_ready`/`is_last`. After each word it waits for the permutation to absorb the block before fetching the next. It zero-masks the unused digit slots of the final word so the padder's byte-count logic sees clean data.

---
 rtl/hash_feeder.sv | 144 ++++++++++++++
 tb/tb_hash_feeder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_feeder.sv
// hash_feeder: walks the packed-vector RAM one word at a time and hands each
// word to the SHA3 padder, waiting for the permutation to absorb it before
// fetching the next. Unused element slots of the final word are zeroed.
module hash_feeder #(
    parameter int unsigned n         = 47,
    parameter int unsigned m         = 79,
    parameter int unsigned digit     = 3,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [m*digit-1:0]   mem_dout,
    output logic [m*digit-1:0]   out,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 perm_ack,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned W          = m * digit;
    localparam int unsigned WORDS      = (n + digit - 1) / digit;
    localparam int unsigned LAST_DIGIT = ((n % digit) == 0) ? digit : (n % digit);
    localparam int unsigned MASK_BITS  = m * (digit - LAST_DIGIT);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [W-1:0]      ALL_ONES  = '1;
    // Element 0 sits in the MSBs, so the unused trailing slots are the low bits.
    localparam logic [W-1:0]      KEEP_MASK = ALL_ONES << MASK_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              idx_clr, idx_inc;
    logic              is_last;
    logic [1:0]        rst_sync;
    logic              rst;

    assign is_last  = (idx == LAST_IDX);
    assign mem_addr = BASE + idx;
    assign rst      = rst_sync[1];

    // Reset asserts immediately, releases two clocks after rst_b falls.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            rst_sync <= '1;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and word-index control; acks are only honoured
    // while a block is outstanding (ISSUE / WAIT_ACK).
    always_comb begin
        state_nxt = state;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_READ;
                    idx_clr   = 1'b1;
                end
            end
            ST_READ:  state_nxt = ST_CAPT;
            ST_CAPT:  state_nxt = ST_ISSUE;
            ST_ISSUE, ST_WAIT_ACK: begin
                if (perm_ack) begin
                    if (is_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_READ;
                        idx_inc   = 1'b1;
                    end
                end else begin
                    state_nxt = ST_WAIT_ACK;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        mem_rd    = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_READ:  mem_rd = 1'b1;
            ST_ISSUE: begin
                out_valid = 1'b1;
                out_last  = is_last;
            end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Word index: cleared on start, advanced on each non-final ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (idx_clr) begin
            idx <= '0;
        end else if (idx_inc) begin
            idx <= idx + 1'b1;
        end
    end

    // Capture RAM data; the final word has its unused element slots zeroed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (state == ST_CAPT) begin
            out <= is_last ? (mem_dout & KEEP_MASK) : mem_dout;
        end
    end

endmodule

// File: tb/tb_hash_feeder.sv
// Bench for hash_feeder: a table of run scenarios (ack delay, stray inputs,
// back-to-back) with random RAM contents, plus reset/abort sequences.
// An n=48 instance runs in lockstep to show the final word passes unmasked.
module tb_hash_feeder;

    localparam int unsigned M  = 79;
    localparam int unsigned D  = 3;
    localparam int unsigned W  = M * D;
    localparam int unsigned AW = 5;

    logic          clk, rst_b, start, perm_ack;
    logic          mem_rd, out_valid, out_last, busy, done;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_dout, dout47;
    logic          mem_rd48, ov48, ol48, busy48, done48;
    logic [AW-1:0] mem_addr48;
    logic [W-1:0]  dout48;

    hash_feeder #(.n(47), .m(M), .digit(D), .ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .out(dout47), .out_valid(out_valid), .out_last(out_last),
        .perm_ack(perm_ack), .busy(busy), .done(done)
    );

    hash_feeder #(.n(48), .m(M), .digit(D), .ADDR_W(AW), .BASE_ADDR(0)) dut48 (
        .clk(clk), .rst_b(rst_b), .start(start), .mem_rd(mem_rd48), .mem_addr(mem_addr48),
        .mem_dout(mem_dout), .out(dout48), .out_valid(ov48), .out_last(ol48),
        .perm_ack(perm_ack), .busy(busy48), .done(done48)
    );

    typedef struct {
        int unsigned delay;     // cycles between out_valid and perm_ack
        bit          stray;     // stray acks in READ/CAPT, stray start mid-run
        bit          b2b;       // second start in the cycle busy falls
        bit          ones_last; // word 15 forced to all ones
        int unsigned exp_done;  // cycle of done counted from start (mem_rd = 1)
        int unsigned exp_space; // cycles between out_valid pulses
    } vec_t;

    typedef struct {
        int unsigned  cyc;
        logic [W-1:0] d47;
        logic [W-1:0] d48;
        logic         l47;
        logic         l48;
    } pulse_t;

    logic [W-1:0] ram [0:31];
    logic [AW-1:0] addr_q [$];
    pulse_t        pulse_q [$];
    int unsigned   done_q [$];

    int unsigned total, bad;
    int unsigned ack_delay, b2b_left, start_pending, start_served;
    bit          stray;

    int unsigned  cyc, cnt;
    bit           pend, was_rd, prev_busy, just_started;
    logic [W-1:0] prev_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM read port, data valid the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_rd) mem_dout <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected padder word k: element slots beyond the vector length are zero.
    function automatic logic [W-1:0] model(input int unsigned k, input int unsigned nn);
        logic [W-1:0] r;
        r = ram[k];
        for (int unsigned e = 0; e < D; e++) begin
            if (k * D + e >= nn) r[W-1-M*e -: M] = '0;
        end
        return r;
    endfunction

    // Per-cycle monitor and responder, sampling 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (rst_b) begin
            start = 1'b0; perm_ack = 1'b0; pend = 1'b0; was_rd = 1'b0;
            prev_busy = 1'b0; just_started = 1'b0; prev_out = '0;
        end else begin
            cyc++;
            chk("last_without_valid", W'(out_last & ~out_valid), '0);
            chk("lockstep_48", W'({mem_rd48, mem_addr48, ov48, busy48, done48}),
                W'({mem_rd, mem_addr, out_valid, busy, done}));
            if (!out_valid) chk("out_hold", dout47, prev_out);
            prev_out = dout47;
            if (just_started) begin
                chk("read_after_start", W'({busy, mem_rd, mem_addr}), W'({1'b1, 1'b1, 5'd0}));
                just_started = 1'b0;
            end
            if (done) chk("busy_during_done", W'(busy), W'(1));
            if (mem_rd) addr_q.push_back(mem_addr);
            if (out_valid) begin
                pulse_q.push_back('{cyc, dout47, dout48, out_last, ol48});
                pend = 1'b1;
                cnt  = ack_delay;
            end
            if (done) done_q.push_back(cyc);

            perm_ack = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    perm_ack = 1'b1;
                    pend     = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (stray && (mem_rd || was_rd)) perm_ack = 1'b1;
            was_rd = mem_rd;

            start = 1'b0;
            if (start_served != start_pending) begin
                start = 1'b1; start_served++; cyc = 0; just_started = 1'b1;
            end else if (b2b_left > 0 && prev_busy && !busy) begin
                start = 1'b1; b2b_left--; cyc = 0; just_started = 1'b1;
            end else if (stray && out_valid && pulse_q.size() == 6) begin
                start = 1'b1;
            end
            prev_busy = busy;
        end
    end

    task automatic fill_ram(input bit ones_last);
        for (int i = 0; i < 32; i++) begin
            logic [W-1:0] v;
            v = '0;
            for (int j = 0; j < 8; j++) v = (v << 32) | W'($urandom());
            ram[i] = v;
        end
        if (ones_last) ram[15] = '1;
    endtask

    task automatic clear_logs();
        addr_q.delete();
        pulse_q.delete();
        done_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int unsigned runs, waited;
        fill_ram(v.ones_last);
        clear_logs();
        ack_delay = v.delay;
        stray     = v.stray;
        b2b_left  = v.b2b ? 1 : 0;
        runs      = v.b2b ? 2 : 1;
        start_pending++;
        waited = 0;
        while (done_q.size() < runs && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        chk($sformatf("v%0d_done_count", vi), W'(done_q.size()), W'(runs));
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_idle_after", vi), W'(busy), '0);
        chk($sformatf("v%0d_addr_count", vi), W'(addr_q.size()), W'(16 * runs));
        for (int i = 0; i < addr_q.size(); i++)
            chk($sformatf("v%0d_addr%0d", vi, i), W'(addr_q[i]), W'(i % 16));
        chk($sformatf("v%0d_pulse_count", vi), W'(pulse_q.size()), W'(16 * runs));
        for (int i = 0; i < pulse_q.size(); i++) begin
            int unsigned k;
            k = i % 16;
            chk($sformatf("v%0d_word%0d_n47", vi, i), pulse_q[i].d47, model(k, 47));
            chk($sformatf("v%0d_word%0d_n48", vi, i), pulse_q[i].d48, model(k, 48));
            chk($sformatf("v%0d_last%0d", vi, i), W'({pulse_q[i].l47, pulse_q[i].l48}),
                W'({k == 15, k == 15}));
            if (k == 0)
                chk($sformatf("v%0d_first_valid%0d", vi, i), W'(pulse_q[i].cyc), W'(3));
            else
                chk($sformatf("v%0d_spacing%0d", vi, i),
                    W'(pulse_q[i].cyc - pulse_q[i-1].cyc), W'(v.exp_space));
        end
        for (int r = 0; r < done_q.size(); r++)
            chk($sformatf("v%0d_done_cycle%0d", vi, r), W'(done_q[r]), W'(v.exp_done));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, W'({out_valid, out_last, mem_rd, busy, done}), '0);
        chk({tag, "_addr"}, W'(mem_addr), '0);
        chk({tag, "_out"}, dout47, '0);
        chk({tag, "_out48"}, dout48, '0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{delay: 0,  stray: 0, b2b: 0, ones_last: 0, exp_done: 49,  exp_space: 3};
        vecs[1] = '{delay: 0,  stray: 0, b2b: 0, ones_last: 1, exp_done: 49,  exp_space: 3};
        vecs[2] = '{delay: 24, stray: 0, b2b: 0, ones_last: 0, exp_done: 433, exp_space: 27};
        vecs[3] = '{delay: 1,  stray: 1, b2b: 0, ones_last: 0, exp_done: 65,  exp_space: 4};
        vecs[4] = '{delay: 5,  stray: 1, b2b: 0, ones_last: 1, exp_done: 129, exp_space: 8};
        vecs[5] = '{delay: 2,  stray: 0, b2b: 1, ones_last: 0, exp_done: 81,  exp_space: 5};

        total = 0; bad = 0;
        ack_delay = 0; stray = 0; b2b_left = 0;
        start_pending = 0; start_served = 0; cyc = 0;
        start = 1'b0; perm_ack = 1'b0;
        fill_ram(1'b0);
        rst_b = 1'b1;
        #1;
        chk_all_zero("reset");
        repeat (4) @(negedge clk);
        rst_b = 1'b0;
        repeat (5) @(negedge clk);
        chk_all_zero("post_reset");

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Abort after word 5 has been issued: outputs clear at once, no done.
        begin
            int unsigned waited, done_before;
            fill_ram(1'b0);
            clear_logs();
            ack_delay = 1; stray = 0; b2b_left = 0;
            start_pending++;
            waited = 0;
            while (pulse_q.size() < 6 && waited < 500) begin
                @(negedge clk);
                waited++;
            end
            chk("abort_reached_word5", W'(pulse_q.size()), W'(6));
            done_before = done_q.size();
            rst_b = 1'b1;
            #1;
            chk_all_zero("abort");
            repeat (3) @(negedge clk);
            rst_b = 1'b0;
            repeat (6) @(negedge clk);
            chk("abort_no_done", W'(done_q.size()), W'(done_before));
            chk("abort_no_more_words", W'(pulse_q.size()), W'(6));
            chk_all_zero("abort_idle");
        end

        // Fresh start after the abort must begin again at address 0.
        run_vec(vecs[0], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
